// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor, LSB first, valid/ready on both sides
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             V,
    output logic             Z
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_sr;
    logic [WIDTH-1:0]  b_sr;
    logic              borrow;
    logic [CW-1:0]     cnt;
    logic              a_msb;
    logic              b_msb;

    logic              d;
    logic              borrow_nxt;
    logic [WIDTH-1:0]  diff_nxt;
    logic              last_bit;

    // Single full-subtractor cell operating on the low bits of the shift registers.
    always_comb begin
        d                   = a_sr[0] ^ b_sr[0] ^ borrow;
        borrow_nxt          = (~a_sr[0] & b_sr[0]) | (~a_sr[0] & borrow) | (b_sr[0] & borrow);
        diff_nxt            = Diff >> 1;
        diff_nxt[WIDTH-1]   = d;
        last_bit            = (cnt == CW'(WIDTH - 1));
    end

    // Held low during reset so no operand is taken while the block is being cleared.
    assign in_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            borrow    <= 1'b0;
            cnt       <= '0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            out_valid <= 1'b0;
            Diff      <= '0;
            Bout      <= 1'b0;
            V         <= 1'b0;
            Z         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr   <= A;
                        b_sr   <= B;
                        borrow <= Bin;
                        cnt    <= '0;
                        a_msb  <= A[WIDTH-1];
                        b_msb  <= B[WIDTH-1];
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    borrow <= borrow_nxt;
                    Diff   <= diff_nxt;
                    cnt    <= cnt + CW'(1);
                    // Flags are registered from the final bit so they appear together with out_valid.
                    if (last_bit) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        Bout      <= borrow_nxt;
                        V         <= (a_msb ^ b_msb) & (a_msb ^ diff_nxt[WIDTH-1]);
                        Z         <= (diff_nxt == '0);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and random checks of serial_subtractor at WIDTH 1, 8 and 32
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        opbin;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready;
    logic [2:0]  bout;
    logic [2:0]  vflag;
    logic [2:0]  zflag;
    logic [0:0]  diff1;
    logic [7:0]  diff8;
    logic [31:0] diff32;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .A(opa[0:0]), .B(opb[0:0]), .Bin(opbin), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .Diff(diff1), .Bout(bout[0]), .V(vflag[0]), .Z(zflag[0])
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .A(opa[7:0]), .B(opb[7:0]), .Bin(opbin), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .Diff(diff8), .Bout(bout[1]), .V(vflag[1]), .Z(zflag[1])
    );

    serial_subtractor #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .A(opa), .B(opb), .Bin(opbin), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .Diff(diff32), .Bout(bout[2]), .V(vflag[2]), .Z(zflag[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int wsel(input int sel);
        return (sel == 0) ? 1 : (sel == 1) ? 8 : 32;
    endfunction

    function automatic logic [31:0] get_diff(input int sel);
        case (sel)
            0:       return {31'b0, diff1};
            1:       return {24'b0, diff8};
            default: return diff32;
        endcase
    endfunction

    function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic bi, output logic [31:0] d, output logic bo,
                                  output logic vo, output logic zo);
        logic [31:0] m;
        logic [32:0] full;
        m    = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        full = {1'b0, a & m} - {1'b0, b & m} - {32'b0, bi};
        d    = full[31:0] & m;
        bo   = full[w];
        vo   = (a[w-1] ^ b[w-1]) & (a[w-1] ^ d[w-1]);
        zo   = (d == 32'd0);
    endfunction

    // Called and returns at a falling edge; drives one operation through and checks it.
    task automatic do_op(input int sel, input logic [31:0] a, input logic [31:0] b, input logic bi,
                         input logic [31:0] ed, input logic eb, input logic ev, input logic ez,
                         input string tag);
        int w;
        int n;
        w = wsel(sel);
        opa = a;
        opb = b;
        opbin = bi;
        out_ready[sel] = 1'b1;
        in_valid[sel] = 1'b1;
        @(negedge clk);
        in_valid[sel] = 1'b0;
        n = 0;
        while (!out_valid[sel] && n < w + 4) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".latency"}, n, w);
        check({tag, ".diff"}, get_diff(sel), ed);
        check({tag, ".bout"}, {31'b0, bout[sel]}, {31'b0, eb});
        check({tag, ".v"}, {31'b0, vflag[sel]}, {31'b0, ev});
        check({tag, ".z"}, {31'b0, zflag[sel]}, {31'b0, ez});
        @(negedge clk);
        check({tag, ".drain_valid"}, {31'b0, out_valid[sel]}, 32'd0);
        check({tag, ".drain_ready"}, {31'b0, in_ready[sel]}, 32'd1);
    endtask

    initial begin
        int n;
        logic [31:0] ra, rb, ed;
        logic rbi, eb, ev, ez;

        rst = 1'b1;
        opa = '0;
        opb = '0;
        opbin = 1'b0;
        in_valid = '0;
        out_ready = '0;
        repeat (3) @(negedge clk);
        check("rst.in_ready", {31'b0, in_ready[1]}, 32'd0);
        check("rst.out_valid", {31'b0, out_valid[1]}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst.in_ready", {29'b0, in_ready}, 32'd7);
        check("post_rst.diff", {24'b0, diff8}, 32'd0);
        check("post_rst.flags", {29'b0, bout[1], vflag[1], zflag[1]}, 32'd0);
        @(negedge clk);

        do_op(1, 32'd10,  32'd3,   1'b0, 32'h07, 1'b0, 1'b0, 1'b0, "t1");
        do_op(1, 32'h00,  32'h01,  1'b0, 32'hFF, 1'b1, 1'b0, 1'b0, "t2");
        do_op(1, 32'h80,  32'h01,  1'b0, 32'h7F, 1'b0, 1'b1, 1'b0, "t3a");
        do_op(1, 32'h7F,  32'hFF,  1'b0, 32'h80, 1'b1, 1'b1, 1'b0, "t3b");
        do_op(1, 32'd5,   32'd4,   1'b1, 32'h00, 1'b0, 1'b0, 1'b1, "t4a");
        do_op(1, 32'd0,   32'd0,   1'b1, 32'hFF, 1'b1, 1'b0, 1'b0, "t4b");

        // Backpressure: result must hold and new operands must be ignored.
        opa = 32'd10;
        opb = 32'd3;
        opbin = 1'b0;
        out_ready[1] = 1'b0;
        in_valid[1] = 1'b1;
        @(negedge clk);
        in_valid[1] = 1'b0;
        n = 0;
        while (!out_valid[1] && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("bp.latency", n, 8);
        opa = 32'h55;
        opb = 32'h11;
        in_valid[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp.diff", {24'b0, diff8}, 32'h07);
            check("bp.in_ready", {31'b0, in_ready[1]}, 32'd0);
            check("bp.out_valid", {31'b0, out_valid[1]}, 32'd1);
        end
        in_valid[1] = 1'b0;
        out_ready[1] = 1'b1;
        @(negedge clk);
        check("bp.drain_valid", {31'b0, out_valid[1]}, 32'd0);
        check("bp.drain_ready", {31'b0, in_ready[1]}, 32'd1);
        check("bp.diff_kept", {24'b0, diff8}, 32'h07);

        // Reset during the third RUN cycle abandons the operation.
        opa = 32'd10;
        opb = 32'd3;
        in_valid[1] = 1'b1;
        @(negedge clk);
        in_valid[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst.out_valid", {31'b0, out_valid[1]}, 32'd0);
        check("midrst.in_ready_low", {31'b0, in_ready[1]}, 32'd0);
        rst = 1'b0;
        #1;
        check("midrst.in_ready", {31'b0, in_ready[1]}, 32'd1);
        check("midrst.diff", {24'b0, diff8}, 32'd0);
        @(negedge clk);
        do_op(1, 32'd200, 32'd55, 1'b0, 32'd145, 1'b0, 1'b0, 1'b0, "t6");

        for (int sel = 0; sel < 3; sel++) begin
            for (int k = 0; k < 1000; k++) begin
                ra = $urandom;
                rb = $urandom;
                rbi = 1'($urandom_range(0, 1));
                model(wsel(sel), ra, rb, rbi, ed, eb, ev, ez);
                do_op(sel, ra, rb, rbi, ed, eb, ev, ez, $sformatf("rnd_w%0d", wsel(sel)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
